// File: rtl/vga_raster_if.sv
// Raster bundle between the VGA timing core and the drawing objects/pins.
// The master side owns the raster counters and pin outputs; the slave side drives draw requests.
interface vga_raster_if;
  logic       drawing_request;
  logic [7:0] rgb_in;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       pix_en;
  logic [7:0] vga_rgb;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_blank_n;
  logic       frame_start;

  modport master (
    input  drawing_request, rgb_in,
    output pixel_x, pixel_y, pix_en, vga_rgb, vga_hsync, vga_vsync, vga_blank_n, frame_start
  );

  modport slave (
    output drawing_request, rgb_in,
    input  pixel_x, pixel_y, pix_en, vga_rgb, vga_hsync, vga_vsync, vga_blank_n, frame_start
  );
endinterface

// File: rtl/vga_raster_controller.sv
// 640x480@60 raster generator: divided pixel enable, h/v counters, and a one-pixel
// registered output stage that keeps colour, sync and blank mutually aligned.
module vga_raster_controller #(
  parameter int         H_ACTIVE = 640,
  parameter int         H_FP     = 16,
  parameter int         H_SYNC   = 96,
  parameter int         H_BP     = 48,
  parameter int         V_ACTIVE = 480,
  parameter int         V_FP     = 10,
  parameter int         V_SYNC   = 2,
  parameter int         V_BP     = 33,
  parameter int         CLK_DIV  = 2,
  parameter logic [7:0] BG_COLOR = 8'b000_000_00
) (
  input  logic          CLK_50,
  input  logic          reset,
  vga_raster_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic [7:0]       r_rgb;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_blank_n;
  logic             r_frame_start;

  logic             w_pix_en;
  logic             w_line_end;
  logic             w_active;
  logic             w_hsync_zone;
  logic             w_vsync_zone;
  logic             w_frame_origin;
  logic [7:0]       w_pixel_color;

  // With CLK_DIV=1 the counter sits at 0 == DIV_LAST, so the enable is constantly high.
  assign w_pix_en       = (r_div_cnt == DIV_LAST);
  assign w_line_end     = (r_h_cnt == H_LAST);
  assign w_active       = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hsync_zone   = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign w_vsync_zone   = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  assign w_frame_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_pixel_color  = !w_active ? 8'h00 : (bus.drawing_request ? bus.rgb_in : BG_COLOR);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_pix_en) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_en) begin
      if (w_line_end) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Pin stage samples the counters that pixel_x/pixel_y present, hence one pixel of lag.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_rgb     <= 8'h00;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_blank_n <= 1'b0;
    end else if (w_pix_en) begin
      r_rgb     <= w_pixel_color;
      r_hsync   <= !w_hsync_zone;
      r_vsync   <= !w_vsync_zone;
      r_blank_n <= w_active;
    end
  end

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_en && w_frame_origin;
    end
  end

  assign bus.pixel_x     = r_h_cnt;
  assign bus.pixel_y     = r_v_cnt;
  assign bus.pix_en      = w_pix_en;
  assign bus.vga_rgb     = r_rgb;
  assign bus.vga_hsync   = r_hsync;
  assign bus.vga_vsync   = r_vsync;
  assign bus.vga_blank_n = r_blank_n;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_raster_controller.sv
// Directed bench: full-size raster for line/pixel checks, a shrunken CLK_DIV=1 raster
// for whole-frame vsync, frame_start and background-colour checks.
module tb_vga_raster_controller;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #10 clk = ~clk;

  vga_raster_if if_a ();
  vga_raster_if if_b ();

  vga_raster_controller u_dut_a (
    .CLK_50 (clk),
    .reset  (rst_a),
    .bus    (if_a)
  );

  // Small raster: H_TOTAL=15 (hsync h 10..12), V_TOTAL=11 (vsync v 8..9), 165-cycle frame.
  vga_raster_controller #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (2),
    .V_ACTIVE (6),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (1),
    .CLK_DIV  (1),
    .BG_COLOR (8'h1C)
  ) u_dut_b (
    .CLK_50 (clk),
    .reset  (rst_b),
    .bus    (if_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int pe_err, hs_low, hs_fall1, hs_fall2, hs_fall_px, blank_low, fs_cnt, fs_first;
    int e3_cnt, e3_pos_err, bg_err, vs_low, ff_cnt, act_err, blk_err, waited;
    int fs_b1, fs_b2, vs_b, hs_b, ff_b, blank_b, blk_b, bg_b, ff_b2;
    logic hs_prev;

    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.drawing_request = 1'b0;
    if_a.rgb_in          = 8'h00;
    if_b.drawing_request = 1'b1;
    if_b.rgb_in          = 8'hFF;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_pixel_x", if_a.pixel_x, 0);
    check("rst_pixel_y", if_a.pixel_y, 0);
    check("rst_rgb",     if_a.vga_rgb, 0);
    check("rst_hsync",   if_a.vga_hsync, 1);
    check("rst_vsync",   if_a.vga_vsync, 1);
    check("rst_blank_n", if_a.vga_blank_n, 0);
    check("rst_frame_start", if_a.frame_start, 0);
    check("rst_pix_en",  if_a.pix_en, 0);

    // Six lines from release: pixel pacing, hsync, blank, frame_start, single drawn pixel
    pe_err = 0; hs_low = 0; hs_fall1 = -1; hs_fall2 = -1; hs_fall_px = -1;
    blank_low = 0; fs_cnt = 0; fs_first = -1; e3_cnt = 0; e3_pos_err = 0;
    bg_err = 0; vs_low = 0; hs_prev = 1'b1;
    rst_a = 1'b0;
    for (int n = 1; n <= 9600; n++) begin
      step();
      if (if_a.pix_en !== 1'(n % 2)) pe_err++;
      if (n == 1) begin
        check("n1_pixel_x", if_a.pixel_x, 0);
        check("n1_frame_start", if_a.frame_start, 0);
      end
      if (n == 2) begin
        check("n2_pixel_x", if_a.pixel_x, 1);
        check("n2_frame_start", if_a.frame_start, 1);
        check("n2_blank_n", if_a.vga_blank_n, 1);
      end
      if (n == 4) check("n4_pixel_x", if_a.pixel_x, 2);
      if (!if_a.vga_hsync && hs_prev) begin
        if (hs_fall1 < 0) begin
          hs_fall1   = n;
          hs_fall_px = int'(if_a.pixel_x);
        end else if (hs_fall2 < 0) begin
          hs_fall2 = n;
        end
      end
      hs_prev = if_a.vga_hsync;
      if (!if_a.vga_hsync && n < 1600) hs_low++;
      if (n >= 2 && n <= 1601 && !if_a.vga_blank_n) blank_low++;
      if (if_a.frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = n;
      end
      if (!if_a.vga_vsync) vs_low++;
      if (if_a.vga_rgb == 8'hE3) begin
        e3_cnt++;
        if (!(if_a.pixel_x == 10'd11 && if_a.pixel_y == 10'd5)) e3_pos_err++;
      end else if (if_a.vga_rgb != 8'h00) begin
        bg_err++;
      end
      if (if_a.pixel_x == 10'd10 && if_a.pixel_y == 10'd5) begin
        if_a.drawing_request = 1'b1;
        if_a.rgb_in          = 8'hE3;
      end else begin
        if_a.drawing_request = 1'b0;
        if_a.rgb_in          = 8'h5A;
      end
    end
    check("pix_en_pattern_errs", pe_err, 0);
    check("hsync_first_fall_cycle", hs_fall1, 1314);
    check("hsync_first_fall_px", hs_fall_px, 657);
    check("hsync_low_cycles", hs_low, 192);
    check("hsync_line_period", hs_fall2 - hs_fall1, 1600);
    check("blank_low_cycles_line", blank_low, 320);
    check("frame_start_count", fs_cnt, 1);
    check("frame_start_cycle", fs_first, 2);
    check("vsync_low_lines0_5", vs_low, 0);
    check("e3_cycles", e3_cnt, 2);
    check("e3_position_errs", e3_pos_err, 0);
    check("bg_errs", bg_err, 0);

    // Constant request with colour FF over one full line
    if_a.drawing_request = 1'b1;
    if_a.rgb_in          = 8'hFF;
    waited = 0;
    while (!(if_a.pixel_x == 10'd1 && !if_a.pix_en) && waited < 2000) begin
      step();
      waited++;
    end
    check("wait_line_start_timeout", 32'(waited < 2000), 1);
    ff_cnt = 0; act_err = 0; blk_err = 0;
    for (int n = 0; n < 1600; n++) begin
      if (n > 0) step();
      if (if_a.vga_rgb == 8'hFF) ff_cnt++;
      if (if_a.vga_blank_n && if_a.vga_rgb != 8'hFF) act_err++;
      if (!if_a.vga_blank_n && if_a.vga_rgb != 8'h00) blk_err++;
    end
    check("ff_cycles_line", ff_cnt, 1280);
    check("ff_active_errs", act_err, 0);
    check("ff_blank_errs", blk_err, 0);

    // Mid-line reset at pixel_x=300
    waited = 0;
    while (if_a.pixel_x != 10'd300 && waited < 2000) begin
      step();
      waited++;
    end
    check("wait_x300_timeout", 32'(waited < 2000), 1);
    rst_a = 1'b1;
    #1;
    check("mid_rst_pixel_x", if_a.pixel_x, 0);
    check("mid_rst_pixel_y", if_a.pixel_y, 0);
    check("mid_rst_rgb", if_a.vga_rgb, 0);
    check("mid_rst_blank_n", if_a.vga_blank_n, 0);
    check("mid_rst_hsync", if_a.vga_hsync, 1);
    repeat (3) step();
    check("mid_rst_held_pixel_x", if_a.pixel_x, 0);
    check("mid_rst_held_frame_start", if_a.frame_start, 0);
    rst_a = 1'b0;
    step();
    check("resume_n1_pix_en", if_a.pix_en, 1);
    check("resume_n1_pixel_x", if_a.pixel_x, 0);
    step();
    check("resume_n2_pixel_x", if_a.pixel_x, 1);
    check("resume_n2_pixel_y", if_a.pixel_y, 0);
    check("resume_n2_frame_start", if_a.frame_start, 1);
    check("resume_n2_rgb", if_a.vga_rgb, 8'hFF);

    // Small raster, two full frames: request FF in the first, none in the second
    fs_b1 = -1; fs_b2 = -1; fs_cnt = 0; vs_b = 0; hs_b = 0; ff_b = 0;
    blank_b = 0; blk_b = 0; bg_b = 0; ff_b2 = 0;
    rst_b = 1'b0;
    for (int n = 1; n <= 330; n++) begin
      step();
      if (if_b.frame_start) begin
        fs_cnt++;
        if (fs_b1 < 0) fs_b1 = n;
        else if (fs_b2 < 0) fs_b2 = n;
      end
      if (!if_b.vga_blank_n && if_b.vga_rgb != 8'h00) blk_b++;
      if (n <= 165) begin
        if (!if_b.vga_vsync) vs_b++;
        if (!if_b.vga_hsync) hs_b++;
        if (if_b.vga_rgb == 8'hFF) ff_b++;
        if (if_b.vga_blank_n) blank_b++;
      end else begin
        if (if_b.vga_rgb == 8'h1C) bg_b++;
        if (if_b.vga_rgb == 8'hFF) ff_b2++;
      end
      if (n >= 165) if_b.drawing_request = 1'b0;
    end
    check("b_frame_start_count", fs_cnt, 2);
    check("b_frame_start_first", fs_b1, 1);
    check("b_frame_period", fs_b2 - fs_b1, 165);
    check("b_vsync_low_cycles", vs_b, 30);
    check("b_hsync_low_cycles", hs_b, 33);
    check("b_ff_cycles", ff_b, 48);
    check("b_blank_high_cycles", blank_b, 48);
    check("b_blank_rgb_errs", blk_b, 0);
    check("b_bg_cycles", bg_b, 48);
    check("b_ff_after_release", ff_b2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_raster_controller.md
Name: vga_raster_controller

Overview:
- Generates 640x480@60 Hz VGA raster timing from CLK_50 using a divided pixel enable.
- Drives pixel_x/pixel_y to all on-screen drawing objects (counter overlays, bitmaps) and accepts their combined drawing request and 8-bit RGB.
- Registers the final pixel colour together with delay-matched sync and blank signals to the DAC/connector pins.
- This is the raster source and pixel sink that overlay blocks consume and feed.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, CLK_50 cycles per pixel (minimum 1)
- BG_COLOR, 8'b000_000_00, colour for active pixels with no drawing request

Ports:
- CLK_50  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- drawing_request  in  1  combined object draw request for current pixel_x/pixel_y
- rgb_in  in  8  object colour, RRR_GGG_BB, valid when drawing_request=1
- pixel_x  out  10  current horizontal count 0..799, includes blanking
- pixel_y  out  10  current vertical count 0..524, includes blanking
- pix_en  out  1  one-CLK_50 strobe; pixel counters advance on this cycle
- vga_rgb  out  8  registered output colour
- vga_hsync  out  1  registered hsync, active-low
- vga_vsync  out  1  registered vsync, active-low
- vga_blank_n  out  1  registered, 1 = active video
- frame_start  out  1  one-CLK_50 pulse at start of frame

Behaviour:
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt == CLK_DIV-1). CLK_DIV=1 gives pix_en constantly 1.
- Horizontal counter: h_cnt advances only on pix_en. H_TOTAL = 800; wraps H_TOTAL-1 -> 0.
- Vertical counter: v_cnt increments on pix_en when h_cnt = H_TOTAL-1. V_TOTAL = 525; wraps V_TOTAL-1 -> 0 at the same edge.
- pixel_x = h_cnt and pixel_y = v_cnt, driven directly from the counter registers. They are stable for a full pixel period.
- Objects respond combinationally within that period.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Output stage: updates only on pix_en, sampling the current counters and inputs.
  - vga_rgb <= !active ? 0 : (drawing_request ? rgb_in : BG_COLOR)
  - vga_hsync <= !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)), i.e. low for h 656..751
  - vga_vsync <= !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)), i.e. low for v 490..491
  - vga_blank_n <= active
- Latency: all pin outputs lag pixel_x/pixel_y by exactly one pixel period, so colour, sync and blank stay mutually aligned.
- frame_start: registered. Set to 1 for exactly one CLK_50 cycle following the pix_en edge at which h_cnt=0 and v_cnt=0 are sampled. 0 otherwise.
- drawing_request/rgb_in are ignored outside active and on non-pix_en cycles.
- Reset values (async, immediate): div_cnt=0, h_cnt=0, v_cnt=0, pixel_x=0, pixel_y=0, vga_rgb=0, vga_hsync=1, vga_vsync=1, vga_blank_n=0, frame_start=0.
- Reset mid-frame: raster restarts at (0,0). The first pix_en after release occurs CLK_DIV cycles after the first active clock edge.
- No other state; no FSM beyond counters. The raster runs continuously.

Test Plan:
- Reset release, CLK_DIV=2 -> pix_en on every 2nd cycle; pixel_x 0,1,2...; first frame_start pulse one cycle after the first pix_en; blank_n=1 from that pix_en.
- Full line -> hsync low for exactly 96 pixels (192 CLK_50 cycles), starting the pixel after pixel_x=656 is sampled; line period 1600 CLK_50 cycles.
- Full frame -> vsync low for 2 lines (pixel_y 490..491 sampled); frame period 800*525*2 = 840000 CLK_50 cycles; exactly one frame_start per frame.
- drawing_request=1 and rgb_in=8'hE3 only when pixel_x=10, pixel_y=5 -> vga_rgb=8'hE3 in the following pixel period; all other active pixels equal BG_COLOR.
- drawing_request=1, rgb_in=8'hFF held constantly -> vga_rgb=0 for all pixels with pixel_x>=640 or pixel_y>=480; 8'hFF otherwise.
- Assert reset at pixel (300,200), release after 3 cycles -> outputs at reset values during reset; raster resumes from (0,0) with correct timing.
